// File: rtl/nv_rwsp_fifo_ctrl_64x129.sv
// Valid/ready FIFO controller around one nv_ram_rwsp_64x129 two-port RAM.
// Owns pointers, occupancy and the RAM's two-stage (address latch, output register) read pipeline.
module nv_rwsp_fifo_ctrl_64x129 #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 129
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW:0]   wr_count,
    output logic          idle,
    input  logic [31:0]   pwrbus_ram_pd_in,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    output logic [31:0]   ram_pwrbus_ram_pd
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   used;
    logic [AW:0]   unissued;
    logic          vld_p1;   // address held in the RAM's read-address latch
    logic          vld_p2;   // RAM output register holds valid data
    logic          push;
    logic          pop;

    assign wr_prdy = (used < FULL_CNT);
    assign push    = wr_pvld & wr_prdy;

    assign ram_we = push;
    assign ram_wa = wr_ptr;
    assign ram_di = wr_pd;

    assign ram_ore = vld_p1 & (~vld_p2 | rd_prdy);
    assign ram_re  = (unissued != '0) & (~vld_p1 | ram_ore);
    assign ram_ra  = rd_ptr;

    assign rd_pvld = vld_p2;
    assign rd_pd   = ram_dout;
    assign pop     = vld_p2 & rd_prdy;

    assign wr_count          = used;
    assign idle              = (used == '0) & ~vld_p1 & ~vld_p2;
    assign ram_pwrbus_ram_pd = pwrbus_ram_pd_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            used     <= '0;
            unissued <= '0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            // Slots are released only on pop, so stalled pipeline entries stay protected.
            case ({push, pop})
                2'b10:   used <= used + CNT_ONE;
                2'b01:   used <= used - CNT_ONE;
                default: used <= used;
            endcase

            case ({push, ram_re})
                2'b10:   unissued <= unissued + CNT_ONE;
                2'b01:   unissued <= unissued - CNT_ONE;
                default: unissued <= unissued;
            endcase

            // Stage boundary: read address issue into the RAM address latch
            if (ram_re) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                vld_p1 <= 1'b1;
            end else if (ram_ore) begin
                vld_p1 <= 1'b0;
            end

            // Stage boundary: RAM output register presents data to the pop side
            vld_p2 <= ram_ore | (vld_p2 & ~rd_prdy);
        end
    end

endmodule

// File: tb/tb_nv_rwsp_fifo_ctrl_64x129.sv
// Bench for nv_rwsp_fifo_ctrl_64x129: behavioural RAM macro, occupancy model and data scoreboard.
module tb_nv_rwsp_fifo_ctrl_64x129;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 129;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic [AW:0]   wr_count;
    logic          idle;
    logic [31:0]   pwrbus_ram_pd_in;
    logic [AW-1:0] ram_wa;
    logic          ram_we;
    logic [DW-1:0] ram_di;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic          ram_ore;
    logic [DW-1:0] ram_dout;
    logic [31:0]   ram_pwrbus_ram_pd;

    always #5 clk = ~clk;

    nv_rwsp_fifo_ctrl_64x129 dut (
        .clk               (clk),
        .rst               (rst),
        .wr_pvld           (wr_pvld),
        .wr_prdy           (wr_prdy),
        .wr_pd             (wr_pd),
        .rd_pvld           (rd_pvld),
        .rd_prdy           (rd_prdy),
        .rd_pd             (rd_pd),
        .wr_count          (wr_count),
        .idle              (idle),
        .pwrbus_ram_pd_in  (pwrbus_ram_pd_in),
        .ram_wa            (ram_wa),
        .ram_we            (ram_we),
        .ram_di            (ram_di),
        .ram_ra            (ram_ra),
        .ram_re            (ram_re),
        .ram_ore           (ram_ore),
        .ram_dout          (ram_dout),
        .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
    );

    // Two-port RAM macro: write port, read-address latch, output register
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra_d;
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_d <= ram_ra;
        if (ram_ore) ram_dout <= mem[ra_d];
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] q[$];
    int            m_used;
    int            pops;
    bit            chk_en;
    bit            s_pvld;
    bit            prev_stall;
    logic [DW-1:0] prev_pd;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, check against model, advance model at posedge.
    task automatic cycle();
        bit m_prdy, push, pop;
        @(negedge clk);
        m_prdy = (m_used < DEPTH);
        if (chk_en && !rst) begin
            chk("wr_prdy", DW'(wr_prdy), DW'(m_prdy));
            chk("wr_count", DW'(wr_count), DW'(m_used));
            chk("idle", DW'(idle), DW'(m_used == 0));
            chk("ram_we", DW'(ram_we), DW'(wr_pvld & m_prdy));
            chk("pwrbus", DW'(ram_pwrbus_ram_pd), DW'(pwrbus_ram_pd_in));
            if (ram_ore) chk("ore_without_s1", DW'(dut.vld_p1), DW'(1'b1));
            if (prev_stall) begin
                chk("stall_vld", DW'(rd_pvld), DW'(1'b1));
                chk("stall_pd", rd_pd, prev_pd);
            end
            if (rd_pvld && rd_prdy) begin
                chk("pop_nonempty", DW'(q.size() != 0), DW'(1'b1));
                if (q.size() != 0) chk("rd_pd", rd_pd, q.pop_front());
                pops++;
            end
        end
        s_pvld     = rd_pvld;
        push       = wr_pvld && m_prdy;
        pop        = rd_pvld && rd_prdy;
        prev_stall = rd_pvld && !rd_prdy;
        prev_pd    = rd_pd;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_used     = 0;
            prev_stall = 1'b0;
        end else begin
            if (push) q.push_back(wr_pd);
            m_used = m_used + int'(push) - int'(pop);
        end
        #1;
    endtask

    initial begin
        chk_en           = 1'b0;
        m_used           = 0;
        pops             = 0;
        prev_stall       = 1'b0;
        rst              = 1'b1;
        wr_pvld          = 1'b0;
        wr_pd            = '0;
        rd_prdy          = 1'b0;
        pwrbus_ram_pd_in = 32'hA5C3_0F1E;
        cycle();
        cycle();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        chk("rst_rd_pvld", DW'(rd_pvld), '0);
        chk("rst_wr_prdy", DW'(wr_prdy), DW'(1'b1));
        chk("rst_wr_count", DW'(wr_count), '0);
        chk("rst_idle", DW'(idle), DW'(1'b1));
        chk("rst_ram_we", DW'(ram_we), '0);
        chk("rst_ram_re", DW'(ram_re), '0);
        chk("rst_ram_ore", DW'(ram_ore), '0);

        // Single push latency
        wr_pvld = 1'b1;
        wr_pd   = {1'b1, 120'h0, 8'hAB};
        rd_prdy = 1'b1;
        cycle();
        wr_pvld = 1'b0;
        cycle();
        chk("lat_cycle1", DW'(s_pvld), '0);
        cycle();
        chk("lat_cycle2", DW'(s_pvld), '0);
        cycle();
        chk("lat_cycle3", DW'(s_pvld), DW'(1'b1));
        cycle();
        chk("lat_idle_after", DW'(idle), DW'(1'b1));

        // Fill to full with the consumer stalled
        rd_prdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_pvld = 1'b1;
            wr_pd   = DW'(i);
            cycle();
        end
        wr_pd = DW'(999);
        for (int i = 0; i < 3; i++) cycle();
        chk("full_count", DW'(wr_count), DW'(64));
        chk("full_prdy", DW'(wr_prdy), '0);

        // Full with simultaneous push and pop
        rd_prdy = 1'b1;
        cycle();
        wr_pvld = 1'b0;
        chk("full_pop_prdy_next", DW'(wr_prdy), DW'(1'b1));
        chk("full_pop_count", DW'(wr_count), DW'(63));
        pops = 0;
        for (int i = 0; i < DEPTH - 1; i++) cycle();
        chk("drain_back_to_back", DW'(pops), DW'(63));
        chk("drain_empty", DW'(q.size()), '0);

        // Continuous streaming across pointer wrap
        pops    = 0;
        wr_pvld = 1'b1;
        rd_prdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            wr_pd = {DW'(i), 32'hC0DE_0000};
            cycle();
        end
        wr_pvld = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("stream_pops", DW'(pops), DW'(200));
        chk("stream_empty", DW'(q.size()), '0);

        // Random push/stall traffic
        for (int i = 0; i < 500; i++) begin
            wr_pvld = 1'($urandom_range(0, 1));
            rd_prdy = 1'($urandom_range(0, 1));
            wr_pd   = DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
            cycle();
        end
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        for (int i = 0; i < 80; i++) cycle();
        chk("random_drained", DW'(q.size()), '0);
        chk("random_idle", DW'(idle), DW'(1'b1));

        // Reset with data buffered and reads in flight
        rd_prdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_pvld = 1'b1;
            wr_pd   = DW'(32'hDEAD_0000 + i);
            cycle();
        end
        wr_pvld = 1'b0;
        rst     = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_rd_pvld", DW'(rd_pvld), '0);
        chk("midrst_wr_count", DW'(wr_count), '0);
        chk("midrst_wr_prdy", DW'(wr_prdy), DW'(1'b1));
        pops    = 0;
        wr_pvld = 1'b1;
        rd_prdy = 1'b1;
        wr_pd   = DW'(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        cycle();
        wr_pvld = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("midrst_fresh_pops", DW'(pops), DW'(1));
        chk("midrst_empty", DW'(q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
